// File: rtl/stack_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one push/pop stack port.
// It accepts one operation per cycle, and each grant is answered by a registered response one cycle later.
module stack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_push,
    input  logic [NUM_REQ-1:0]        req_pop,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_id,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      stk_push,
    output logic                      stk_pop,
    output logic [DATA_W-1:0]         stk_din,
    input  logic                      stk_full,
    input  logic                      stk_empty,
    input  logic [DATA_W-1:0]         stk_dout
);

    logic [NUM_REQ-1:0] active;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_ptr_next;
    logic [2:0]         pick_res;
    logic               found;
    logic [1:0]         sel;
    logic               is_push;
    logic               reject;

    logic               vld_p1;
    logic [1:0]         id_p1;
    logic               pop_p1;
    logic               err_p1;

    // Returns {found, index} of the first active requester at or above ptr, wrapping.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] act, input logic [1:0] ptr);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (int'(ptr) + k) % NUM_REQ;
            if (!r[2] && act[c]) r = {1'b1, c[1:0]};
        end
        return r;
    endfunction

    assign active   = req_push | req_pop;
    assign pick_res = rr_pick(active, rr_ptr);
    assign found    = pick_res[2] & rst_n;
    assign sel      = pick_res[1:0];

    // Push wins when a requester asserts both.
    assign is_push  = req_push[sel];
    assign reject   = is_push ? stk_full : stk_empty;

    always_comb begin
        gnt      = '0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = '0;
        if (found) begin
            gnt[sel] = 1'b1;
            if (is_push && !stk_full) begin
                stk_push = 1'b1;
                stk_din  = req_data[int'(sel)*DATA_W +: DATA_W];
            end
            if (!is_push && !stk_empty) stk_pop = 1'b1;
        end
    end

    assign rr_ptr_next = (sel == 2'(NUM_REQ - 1)) ? 2'd0 : sel + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Stage p1: response register, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            pop_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= found;
            id_p1  <= found ? sel : 2'd0;
            pop_p1 <= found & ~is_push;
            err_p1 <= found & reject;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;
    assign rsp_err   = err_p1;
    // The stack registers its read data, so it lines up with the p1 response.
    assign rsp_data  = (vld_p1 && pop_p1 && !err_p1) ? stk_dout : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed testbench for stack_arbiter.
// A small behavioural LIFO stands in for the stack.
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_push;
    logic [3:0]  req_pop;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_err;
    logic [7:0]  rsp_data;
    logic        stk_push;
    logic        stk_pop;
    logic [7:0]  stk_din;
    logic        stk_full;
    logic        stk_empty;
    logic [7:0]  stk_dout;

    logic        force_full;
    logic        stk_clr;
    logic [7:0]  mem [16];
    logic [4:0]  cnt = '0;
    logic [7:0]  dout = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .stk_full(stk_full), .stk_empty(stk_empty),
        .stk_dout(stk_dout)
    );

    assign stk_full  = force_full | (cnt == 5'd16);
    assign stk_empty = (cnt == 5'd0);
    assign stk_dout  = dout;

    always @(posedge clk) begin
        if (stk_clr) begin
            cnt <= '0;
        end else if (stk_push) begin
            mem[cnt[3:0]] <= stk_din;
            cnt <= cnt + 5'd1;
        end else if (stk_pop) begin
            dout <= mem[cnt[3:0] - 4'd1];
            cnt <= cnt - 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_push = '0; req_pop = '0; req_data = '0;
        force_full = 1'b0; stk_clr = 1'b0;

        // reset state with requests present
        repeat (2) @(posedge clk);
        #1;
        req_push = 4'b1111; req_data = 32'h44332211;
        settle();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_stk_push", 32'(stk_push), 0);
        chk("rst_stk_pop", 32'(stk_pop), 0);
        chk("rst_stk_din", 32'(stk_din), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        req_push = '0; req_data = '0;
        rst_n = 1'b1;

        // single requester push
        tick();
        req_push = 4'b0100; req_data = 32'h00A50000;
        settle();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_stk_push", 32'(stk_push), 1);
        chk("single_stk_pop", 32'(stk_pop), 0);
        chk("single_stk_din", 32'(stk_din), 32'hA5);
        tick();
        req_push = '0; req_data = '0;
        settle();
        chk("single_rsp_valid", 32'(rsp_valid), 1);
        chk("single_rsp_id", 32'(rsp_id), 2);
        chk("single_rsp_err", 32'(rsp_err), 0);
        chk("single_rsp_data", 32'(rsp_data), 0);
        chk("idle_gnt", 32'(gnt), 0);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 0);

        // all four push continuously from reset
        rst_pulse();
        req_push = 4'b1111; req_data = 32'h40302010;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            chk("rr_stk_din", 32'(stk_din), 32'((k % 4 + 1) * 16));
            tick();
            settle();
            chk("rr_rsp_valid", 32'(rsp_valid), 1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
        end
        req_push = '0; req_data = '0;
        stk_clr = 1'b1;
        tick();
        stk_clr = 1'b0;

        // push 0x11 by req 0, then pop by req 3
        req_push = 4'b0001; req_data = 32'h00000011;
        settle();
        chk("pp_push_gnt", 32'(gnt), 32'h1);
        chk("pp_push_din", 32'(stk_din), 32'h11);
        tick();
        req_push = '0; req_data = '0; req_pop = 4'b1000;
        settle();
        chk("pp_pop_gnt", 32'(gnt), 32'h8);
        chk("pp_stk_pop", 32'(stk_pop), 1);
        chk("pp_stk_push", 32'(stk_push), 0);
        tick();
        req_pop = '0;
        settle();
        chk("pp_rsp_valid", 32'(rsp_valid), 1);
        chk("pp_rsp_id", 32'(rsp_id), 3);
        chk("pp_rsp_err", 32'(rsp_err), 0);
        chk("pp_rsp_data", 32'(rsp_data), 32'h11);

        // pop on empty by req 1
        req_pop = 4'b0010;
        settle();
        chk("empty_gnt", 32'(gnt), 32'h2);
        chk("empty_stk_pop", 32'(stk_pop), 0);
        tick();
        req_pop = '0;
        settle();
        chk("empty_rsp_valid", 32'(rsp_valid), 1);
        chk("empty_rsp_err", 32'(rsp_err), 1);
        chk("empty_rsp_data", 32'(rsp_data), 0);

        // preload one entry, then full-stack contention from rr_ptr=0
        req_push = 4'b1000; req_data = 32'h5C000000;
        settle();
        chk("pre_gnt", 32'(gnt), 32'h8);
        tick();
        req_push = '0; req_data = '0;
        rst_pulse();
        force_full = 1'b1;
        req_push = 4'b0001; req_pop = 4'b0010; req_data = 32'h00000077;
        settle();
        chk("full_gnt", 32'(gnt), 32'h1);
        chk("full_stk_push", 32'(stk_push), 0);
        chk("full_stk_din", 32'(stk_din), 0);
        tick();
        req_push = '0; req_data = '0;
        settle();
        chk("full_rsp_valid", 32'(rsp_valid), 1);
        chk("full_rsp_id", 32'(rsp_id), 0);
        chk("full_rsp_err", 32'(rsp_err), 1);
        chk("full_pop_gnt", 32'(gnt), 32'h2);
        chk("full_stk_pop", 32'(stk_pop), 1);
        tick();
        req_pop = '0; force_full = 1'b0;
        settle();
        chk("full_pop_rsp_id", 32'(rsp_id), 1);
        chk("full_pop_rsp_err", 32'(rsp_err), 0);
        chk("full_pop_rsp_data", 32'(rsp_data), 32'h5C);

        // reset during a granted pop
        req_push = 4'b0100; req_data = 32'h003C0000;
        settle();
        chk("rp_push_gnt", 32'(gnt), 32'h4);
        tick();
        req_push = '0; req_data = '0; req_pop = 4'b1000;
        settle();
        chk("rp_pop_gnt", 32'(gnt), 32'h8);
        chk("rp_stk_pop", 32'(stk_pop), 1);
        rst_n = 1'b0;
        settle();
        chk("rp_rst_gnt", 32'(gnt), 0);
        chk("rp_rst_stk_pop", 32'(stk_pop), 0);
        chk("rp_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rp_rst_rsp_id", 32'(rsp_id), 0);
        tick();
        req_pop = 4'b0010; req_push = 4'b1010; req_data = 32'h00009900;
        rst_n = 1'b1;
        settle();
        chk("rp_rel_rsp_valid", 32'(rsp_valid), 0);
        chk("rp_rel_gnt", 32'(gnt), 32'h2);
        chk("rp_both_stk_push", 32'(stk_push), 1);
        chk("rp_both_stk_pop", 32'(stk_pop), 0);
        chk("rp_both_stk_din", 32'(stk_din), 32'h99);
        tick();
        req_pop = '0; req_push = 4'b1000;
        settle();
        chk("rp_next_rsp_id", 32'(rsp_id), 1);
        chk("rp_next_gnt", 32'(gnt), 32'h8);
        req_push = '0; req_data = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
